// File: rtl/phy_tx_lane_serializer.sv
// NUM_LANES-to-1 word serializer for the PHY transmit path: captures a lane bank per frame, emits lane 0 first.
// Optional macro IDLE_FILL_EN: invalid lane slots drive IDLE_SYM on data_out instead of the raw held word.
module phy_tx_lane_serializer #(
   parameter int NUM_LANES = 4,
   parameter int DATA_W    = 8,
   parameter int SEL_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
`ifdef IDLE_FILL_EN
   ,
   parameter logic [DATA_W-1:0] IDLE_SYM = DATA_W'(8'hBC)
`endif
) (
   input  logic                        clk_4f,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUM_LANES*DATA_W-1:0] data_in,
   input  logic [NUM_LANES-1:0]        valid_in,
   output logic                        load,
   output logic [DATA_W-1:0]           data_out,
   output logic                        valid_out,
   output logic [SEL_W-1:0]            lane_out,
   output logic                        frame_start
);

   // Handshake: valid_out qualifies data_out for exactly the cycle it is high. There is no
   // backpressure; enable is the only flow control and pausing drops valid_out to 0.

   logic [SEL_W-1:0]                  sel;
   logic [NUM_LANES-1:0][DATA_W-1:0]  hold_d;
   logic [NUM_LANES-1:0]              hold_v;
   logic                              last_slot;
   logic [DATA_W-1:0]                 cur_d;
   logic                              cur_v;
   logic [DATA_W-1:0]                 next_d;

   assign last_slot = (sel == SEL_W'(NUM_LANES - 1));
   assign load      = enable & ~reset & last_slot;

   // Explicit slot mux so a non-power-of-two lane count never indexes past the bank.
   always_comb begin
      cur_d = '0;
      cur_v = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (sel == SEL_W'(k)) begin
            cur_d = hold_d[k];
            cur_v = hold_v[k];
         end
      end
   end

`ifdef IDLE_FILL_EN
   assign next_d = cur_v ? cur_d : IDLE_SYM;
`else
   assign next_d = cur_d;
`endif

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         sel         <= '0;
         hold_d      <= '0;
         hold_v      <= '0;
         data_out    <= '0;
         valid_out   <= 1'b0;
         lane_out    <= '0;
         frame_start <= 1'b0;
      end else if (enable) begin
         // Output reads the old bank; the capture below lands on the same edge.
         data_out    <= next_d;
         valid_out   <= cur_v;
         lane_out    <= sel;
         frame_start <= (sel == '0);
         sel         <= last_slot ? '0 : sel + SEL_W'(1);
         if (load) begin
            hold_d <= data_in;
            hold_v <= valid_in;
         end
      end else begin
         valid_out   <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Scoreboard bench for phy_tx_lane_serializer: a 4-lane instance and a 1-lane instance.
// Works with or without IDLE_FILL_EN defined.
`timescale 1ns/1ps
module tb_phy_tx_lane_serializer;
   localparam int W = 13;  // {load, data[7:0], valid, lane[1:0], frame_start}
   localparam logic [31:0] JUNK = 32'hDEADBEEF;

   logic clk_4f = 1'b0;
   always #5 clk_4f = ~clk_4f;

   logic        reset, enable;
   logic [31:0] data_in;
   logic [3:0]  valid_in;
   logic        load;
   logic [7:0]  data_out;
   logic        valid_out;
   logic [1:0]  lane_out;
   logic        frame_start;

   logic        reset1, enable1;
   logic [7:0]  data_in1;
   logic        valid_in1;
   logic        load1;
   logic [7:0]  data_out1;
   logic        valid_out1;
   logic        lane_out1;
   logic        frame_start1;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_q1[$];
   int checks = 0;
   int errors = 0;

   phy_tx_lane_serializer #(.NUM_LANES(4), .DATA_W(8)) dut (
      .clk_4f(clk_4f), .reset(reset), .enable(enable), .data_in(data_in), .valid_in(valid_in),
      .load(load), .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out),
      .frame_start(frame_start));

   phy_tx_lane_serializer #(.NUM_LANES(1), .DATA_W(8)) dut1 (
      .clk_4f(clk_4f), .reset(reset1), .enable(enable1), .data_in(data_in1), .valid_in(valid_in1),
      .load(load1), .data_out(data_out1), .valid_out(valid_out1), .lane_out(lane_out1),
      .frame_start(frame_start1));

   function automatic logic [7:0] fill(input logic [7:0] raw);
`ifdef IDLE_FILL_EN
      return 8'hBC;
`else
      return raw;
`endif
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
      end
   endtask

   // One 4-lane cycle: drive inputs for the next edge, queue load now and outputs after that edge.
   task automatic cyc4(input logic rst, input logic en, input logic [31:0] din, input logic [3:0] vin,
                       input logic eload, input logic [7:0] ed, input logic ev,
                       input logic [1:0] elane, input logic efs);
      reset = rst; enable = en; data_in = din; valid_in = vin;
      exp_q.push_back({eload, ed, ev, elane, efs});
      @(posedge clk_4f); #2;
   endtask

   task automatic cyc1(input logic rst, input logic en, input logic [7:0] din, input logic vin,
                       input logic eload, input logic [7:0] ed, input logic ev, input logic efs);
      reset1 = rst; enable1 = en; data_in1 = din; valid_in1 = vin;
      exp_q1.push_back({eload, ed, ev, 2'b00, efs});
      @(posedge clk_4f); #2;
   endtask

   initial begin : monitor
      logic [W-1:0] e0, e1;
      bit h0, h1;
      forever begin
         @(negedge clk_4f);
         h0 = exp_q.size() > 0;
         h1 = exp_q1.size() > 0;
         if (h0) e0 = exp_q.pop_front();
         if (h1) e1 = exp_q1.pop_front();
         if (h0) chk("load", {7'd0, load}, {7'd0, e0[12]});
         if (h1) chk("load1", {7'd0, load1}, {7'd0, e1[12]});
         @(posedge clk_4f); #1;
         if (h0) begin
            chk("data_out", data_out, e0[11:4]);
            chk("valid_out", {7'd0, valid_out}, {7'd0, e0[3]});
            chk("lane_out", {6'd0, lane_out}, {6'd0, e0[2:1]});
            chk("frame_start", {7'd0, frame_start}, {7'd0, e0[0]});
         end
         if (h1) begin
            chk("data_out1", data_out1, e1[11:4]);
            chk("valid_out1", {7'd0, valid_out1}, {7'd0, e1[3]});
            chk("lane_out1", {7'd0, lane_out1}, {6'd0, e1[2:1]});
            chk("frame_start1", {7'd0, frame_start1}, {7'd0, e1[0]});
         end
      end
   end

   initial begin : watchdog
      #50000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin : driver
      reset = 1'b1; enable = 1'b0; data_in = '0; valid_in = '0;
      reset1 = 1'b1; enable1 = 1'b0; data_in1 = '0; valid_in1 = 1'b0;
      @(posedge clk_4f); #2;

      // Reset, including reset overriding enable
      cyc4(1, 0, JUNK, 4'hF, 0, 8'h00, 0, 0, 0);
      cyc4(1, 1, JUNK, 4'hF, 0, 8'h00, 0, 0, 0);
      // Empty first frame, capture {CC,DD,EE,FF}
      cyc4(0, 1, 32'hCCDDEEFF, 4'hF, 0, fill(8'h00), 0, 0, 1);
      cyc4(0, 1, 32'hCCDDEEFF, 4'hF, 0, fill(8'h00), 0, 1, 0);
      cyc4(0, 1, 32'hCCDDEEFF, 4'hF, 0, fill(8'h00), 0, 2, 0);
      cyc4(0, 1, 32'hCCDDEEFF, 4'hF, 1, fill(8'h00), 0, 3, 0);
      // Emit FF,EE,DD,CC; back-to-back frames follow
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hFF, 1, 0, 1);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hEE, 1, 1, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hDD, 1, 2, 0);
      cyc4(0, 1, 32'h8899AABB, 4'hF, 1, 8'hCC, 1, 3, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hBB, 1, 0, 1);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hAA, 1, 1, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h99, 1, 2, 0);
      cyc4(0, 1, 32'h6677DEEA, 4'hF, 1, 8'h88, 1, 3, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hEA, 1, 0, 1);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hDE, 1, 1, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h77, 1, 2, 0);
      cyc4(0, 1, 32'h4455FFCC, 4'b0100, 1, 8'h66, 1, 3, 0);
      // Only lane 2 valid
      cyc4(0, 1, JUNK,         4'hF, 0, fill(8'hCC), 0, 0, 1);
      cyc4(0, 1, JUNK,         4'hF, 0, fill(8'hFF), 0, 1, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h55,       1, 2, 0);
      cyc4(0, 1, 32'h11223344, 4'hF, 1, fill(8'h44), 0, 3, 0);
      // Pause for 3 cycles after lane 1
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h44, 1, 0, 1);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h33, 1, 1, 0);
      for (int i = 0; i < 3; i++) cyc4(0, 0, JUNK, 4'hF, 0, 8'h33, 0, 1, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h22, 1, 2, 0);
      cyc4(0, 1, 32'hA1B2C3D4, 4'hF, 1, 8'h11, 1, 3, 0);
      // Reset at lane 2: rest of frame discarded, next frame empty
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hD4, 1, 0, 1);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'hC3, 1, 1, 0);
      cyc4(1, 1, JUNK,         4'hF, 0, 8'h00, 0, 0, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, fill(8'h00), 0, 0, 1);
      cyc4(0, 1, JUNK,         4'hF, 0, fill(8'h00), 0, 1, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, fill(8'h00), 0, 2, 0);
      cyc4(0, 1, 32'h01020304, 4'hF, 1, fill(8'h00), 0, 3, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h04, 1, 0, 1);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h03, 1, 1, 0);
      cyc4(0, 1, JUNK,         4'hF, 0, 8'h02, 1, 2, 0);
      cyc4(0, 1, JUNK,         4'hF, 1, 8'h01, 1, 3, 0);
      reset = 1'b0; enable = 1'b0;

      // Single-lane instance
      cyc1(1, 1, 8'h00, 0, 0, 8'h00, 0, 0);
      cyc1(0, 1, 8'hA0, 1, 1, fill(8'h00), 0, 1);
      cyc1(0, 1, 8'hA1, 0, 1, 8'hA0, 1, 1);
      cyc1(0, 0, 8'hA2, 1, 0, 8'hA0, 0, 0);
      cyc1(0, 1, 8'hA3, 1, 1, fill(8'hA1), 0, 1);
      cyc1(0, 1, 8'hA4, 1, 1, 8'hA3, 1, 1);
      cyc1(1, 1, 8'hA5, 1, 0, 8'h00, 0, 0);
      cyc1(0, 1, 8'h55, 1, 1, fill(8'h00), 0, 1);
      cyc1(0, 0, 8'h66, 1, 0, fill(8'h00), 0, 0);
      cyc1(0, 1, 8'h77, 1, 1, 8'h55, 1, 1);
      enable1 = 1'b0;

      repeat (3) @(posedge clk_4f);
      #2;
      chk("queues_drained", 8'(exp_q.size() + exp_q1.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
